logic_unit_serial: RTL and testbench

Parametrised, multi-cycle bitwise logic unit. It generalises the lab's single-bit AND/OR/NOT gate set to WIDTH-bit operands and eight logic operations. Operands are evaluated SLICE bits per clock, LSB slice first, under a start/busy/done handshake. It sits between operand registers and the datapath as the slice-serial logic engine for later lab ALUs.

---
 rtl/logic_unit_serial_if.sv | 24 ++
 rtl/logic_unit_serial.sv | 90 +++++++++
 tb/tb_logic_unit_serial.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_serial_if.sv
// Operand/result bundle for logic_unit_serial.
// master drives start and operands, slave drives the result and status.
interface logic_unit_serial_if #(
  parameter int WIDTH = 8
);
  logic             inStart;
  logic [2:0]       inOp;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic [WIDTH-1:0] outResult;
  logic             outBusy;
  logic             outDone;
  logic             outZero;

  modport master (
    output inStart, inOp, inA, inB,
    input  outResult, outBusy, outDone, outZero
  );

  modport slave (
    input  inStart, inOp, inA, inB,
    output outResult, outBusy, outDone, outZero
  );
endinterface

// File: rtl/logic_unit_serial.sv
// Slice-serial bitwise logic unit: evaluates SLICE bits per clock, LSB slice first,
// under a start/busy/done handshake. The result is published only when the last slice is written.
module logic_unit_serial #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input logic                clk,
  input logic                reset,
  logic_unit_serial_if.slave bus
);
  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d, result_q;
  logic [2:0]       op_q;
  logic [KW-1:0]    k_q;
  logic             zero_q;
  logic [SLICE-1:0] a_sl, b_sl, r_sl;
  logic             last_slice;

  always_comb begin
    a_sl = a_q[int'(k_q)*SLICE +: SLICE];
    b_sl = b_q[int'(k_q)*SLICE +: SLICE];
    case (op_q)
      3'b000:  r_sl = a_sl & b_sl;
      3'b001:  r_sl = a_sl | b_sl;
      3'b010:  r_sl = ~a_sl;
      3'b011:  r_sl = ~(a_sl | b_sl);
      3'b100:  r_sl = ~(a_sl & b_sl);
      3'b101:  r_sl = a_sl ^ b_sl;
      3'b110:  r_sl = ~(a_sl ^ b_sl);
      default: r_sl = a_sl;
    endcase
    // acc_d already contains the slice being written, so completion can publish it directly
    acc_d = acc_q;
    acc_d[int'(k_q)*SLICE +: SLICE] = r_sl;
    last_slice = (k_q == KW'(N - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      k_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.inStart) begin
            a_q     <= bus.inA;
            b_q     <= bus.inB;
            op_q    <= bus.inOp;
            acc_q   <= '0;
            k_q     <= '0;
            state_q <= S_BUSY;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_BUSY: begin
          acc_q <= acc_d;
          if (last_slice) begin
            result_q <= acc_d;
            zero_q   <= (acc_d == '0);
            state_q  <= S_DONE;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.outResult = result_q;
  assign bus.outZero   = zero_q;
  assign bus.outBusy   = (state_q == S_BUSY);
  assign bus.outDone   = (state_q == S_DONE);
endmodule

// File: tb/tb_logic_unit_serial.sv
// Bench for logic_unit_serial: three parameterisations checked every cycle against a
// remaining-cycles/whole-word model, plus directed literal checks on the 8/2 instance.
module tb_logic_unit_serial;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic_unit_serial_if #(.WIDTH(8))  if0 ();
  logic_unit_serial_if #(.WIDTH(8))  if1 ();
  logic_unit_serial_if #(.WIDTH(12)) if2 ();

  logic_unit_serial #(.WIDTH(8),  .SLICE(2)) u_dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  logic_unit_serial #(.WIDTH(8),  .SLICE(8)) u_dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  logic_unit_serial #(.WIDTH(12), .SLICE(3)) u_dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

  int n_checks = 0;
  int n_errors = 0;
  bit armed = 1'b0;

  int          ncyc [3] = '{4, 1, 4};
  int          wid  [3] = '{8, 8, 12};
  int          bl   [3] = '{0, 0, 0};
  bit          mdone[3] = '{0, 0, 0};
  logic [11:0] mres [3] = '{12'h0, 12'h0, 12'h0};
  logic [11:0] mpend[3] = '{12'h0, 12'h0, 12'h0};

  function automatic logic [11:0] op_fn(input logic [2:0] op, input logic [11:0] a,
                                        input logic [11:0] b, input int w);
    logic [11:0] r;
    logic [11:0] mask;
    mask = 12'hFFF >> (12 - w);
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = ~a;
      3'd3: r = ~(a | b);
      3'd4: r = ~(a & b);
      3'd5: r = a ^ b;
      3'd6: r = ~(a ^ b);
      default: r = a;
    endcase
    return r & mask;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Model: a start is taken whenever nothing is outstanding; the result appears N edges later.
  task automatic model_step(input int i, input logic st, input logic [2:0] op,
                            input logic [11:0] a, input logic [11:0] b);
    bit take;
    take = (bl[i] == 0) && (st === 1'b1);
    mdone[i] = 1'b0;
    if (bl[i] > 0) begin
      bl[i]--;
      if (bl[i] == 0) begin
        mres[i]  = mpend[i];
        mdone[i] = 1'b1;
      end
    end
    if (take) begin
      mpend[i] = op_fn(op, a, b, wid[i]);
      bl[i]    = ncyc[i];
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        bl[i] = 0; mdone[i] = 1'b0; mres[i] = '0; mpend[i] = '0;
      end
    end else begin
      model_step(0, if0.inStart, if0.inOp, 12'(if0.inA), 12'(if0.inB));
      model_step(1, if1.inStart, if1.inOp, 12'(if1.inA), 12'(if1.inB));
      model_step(2, if2.inStart, if2.inOp, if2.inA, if2.inB);
    end
  end

  task automatic cmp(input int i, input logic busy, input logic done,
                     input logic [11:0] res, input logic z);
    check($sformatf("busy%0d", i),   32'(busy), 32'(bl[i] > 0));
    check($sformatf("done%0d", i),   32'(done), 32'(mdone[i]));
    check($sformatf("result%0d", i), 32'(res),  32'(mres[i]));
    check($sformatf("zero%0d", i),   32'(z),    32'(mres[i] == 12'h0));
  endtask

  always @(negedge clk) begin
    if (armed) begin
      cmp(0, if0.outBusy, if0.outDone, 12'(if0.outResult), if0.outZero);
      cmp(1, if1.outBusy, if1.outDone, 12'(if1.outResult), if1.outZero);
      cmp(2, if2.outBusy, if2.outDone, if2.outResult, if2.outZero);
    end
  end

  task automatic drive0(input logic s, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    if0.inStart = s; if0.inOp = op; if0.inA = a; if0.inB = b;
  endtask

  // Called in the first busy cycle; returns cycles until outDone is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (if0.outDone !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 12) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout at %0t: got no outDone expected within 12 cycles", $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_result"}, 32'(if0.outResult), 32'h0);
    check({tag, "_zero"},   32'(if0.outZero),   32'h1);
    check({tag, "_busy"},   32'(if0.outBusy),   32'h0);
    check({tag, "_done"},   32'(if0.outDone),   32'h0);
  endtask

  logic [7:0] exp_ops[8] = '{8'h00, 8'hFF, 8'h3A, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hC5};

  initial begin
    int lat;
    int cnt;
    drive0(1'b0, 3'd0, 8'h00, 8'h00);
    if1.inStart = 1'b0; if1.inOp = '0; if1.inA = '0; if1.inB = '0;
    if2.inStart = 1'b0; if2.inOp = '0; if2.inA = '0; if2.inB = '0;

    // reset asserted between edges clears outputs without a clock
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check_reset_outputs("rst");
    check("rst_result2", 32'(if2.outResult), 32'h0);
    #1 reset = 1'b0;
    armed = 1'b1;
    repeat (10) @(negedge clk);
    check_reset_outputs("idle");

    for (int op = 0; op < 8; op++) begin
      drive0(1'b1, 3'(op), 8'hC5, 8'h3A);
      @(negedge clk);
      if0.inStart = 1'b0;
      wait_done(lat);
      check($sformatf("op%0d_lat", op), 32'(lat), 32'd4);
      check($sformatf("op%0d_result", op), 32'(if0.outResult), 32'(exp_ops[op]));
      check($sformatf("op%0d_zero", op), 32'(if0.outZero), 32'(op == 0 || op == 3 || op == 6));
    end

    @(negedge clk);
    drive0(1'b1, 3'd5, 8'hF0, 8'h0F);
    @(negedge clk);
    if0.inStart = 1'b0;
    @(negedge clk);
    drive0(1'b1, 3'd0, 8'h00, 8'h55);
    @(negedge clk);
    if0.inStart = 1'b0;
    wait_done(lat);
    check("ignore_lat", 32'(lat + 2), 32'd4);
    check("ignore_result", 32'(if0.outResult), 32'hFF);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      cnt += int'(if0.outDone);
    end
    check("ignore_extra_done", 32'(cnt), 32'd0);

    drive0(1'b1, 3'd0, 8'hAA, 8'h0F);
    @(negedge clk);
    wait_done(lat);
    check("b2b_lat0", 32'(lat), 32'd4);
    check("b2b_result0", 32'(if0.outResult), 32'h0A);
    if0.inOp = 3'd1;
    @(negedge clk);
    wait_done(lat);
    check("b2b_gap", 32'(lat + 1), 32'd5);
    check("b2b_result1", 32'(if0.outResult), 32'hAF);
    if0.inStart = 1'b0;
    repeat (6) @(negedge clk);

    drive0(1'b1, 3'd7, 8'h33, 8'h00);
    @(negedge clk);
    if0.inStart = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    #1 check_reset_outputs("abort");
    #1 reset = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      cnt += int'(if0.outDone);
    end
    check("abort_no_done", 32'(cnt), 32'd0);
    drive0(1'b1, 3'd5, 8'h5A, 8'h0F);
    @(negedge clk);
    if0.inStart = 1'b0;
    wait_done(lat);
    check("after_abort_lat", 32'(lat), 32'd4);
    check("after_abort_result", 32'(if0.outResult), 32'h55);

    // random traffic on all three parameterisations; the compare process does the checking
    repeat (400) begin
      @(negedge clk);
      if0.inStart = ($urandom_range(0, 2) != 0);
      if0.inOp = 3'($urandom); if0.inA = 8'($urandom); if0.inB = 8'($urandom);
      if1.inStart = ($urandom_range(0, 2) != 0);
      if1.inOp = 3'($urandom); if1.inA = 8'($urandom); if1.inB = 8'($urandom);
      if2.inStart = ($urandom_range(0, 2) != 0);
      if2.inOp = 3'($urandom); if2.inA = 12'($urandom); if2.inB = 12'($urandom);
    end
    if0.inStart = 1'b0; if1.inStart = 1'b0; if2.inStart = 1'b0;
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
